// File: rtl/judge_score_display_pkg.sv
// Shared encodings for the judge score display: judge codes, glyphs and score increments.
package judge_score_display_pkg;

  typedef enum logic [1:0] {
    JUDGE_IDLE    = 2'b00,
    JUDGE_MISS    = 2'b01,
    JUDGE_NORMAL  = 2'b10,
    JUDGE_PERFECT = 2'b11
  } judge_t;

  // Glyphs are {dp,g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  localparam logic [1:0] INC_MISS    = 2'd0;
  localparam logic [1:0] INC_NORMAL  = 2'd1;
  localparam logic [1:0] INC_PERFECT = 2'd2;

  function automatic logic [1:0] judge_increment(input logic [1:0] judge);
    case (judge)
      JUDGE_PERFECT: judge_increment = INC_PERFECT;
      JUDGE_NORMAL:  judge_increment = INC_NORMAL;
      default:       judge_increment = INC_MISS;
    endcase
  endfunction

endpackage

// File: rtl/judge_score_display_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment glyph; blank flag or non-BCD value gives an unlit digit.
module bcd_to_seg7
  import judge_score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = GLYPH_0;
        4'd1:    seg = GLYPH_1;
        4'd2:    seg = GLYPH_2;
        4'd3:    seg = GLYPH_3;
        4'd4:    seg = GLYPH_4;
        4'd5:    seg = GLYPH_5;
        4'd6:    seg = GLYPH_6;
        4'd7:    seg = GLYPH_7;
        4'd8:    seg = GLYPH_8;
        4'd9:    seg = GLYPH_9;
        default: seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/judge_score_display.sv
// Saturating BCD score accumulator with judge hold timer and multiplexed 7-segment scan.
// Define SEG_ACTIVE_LOW_EN for active-low o_seg/o_com drive.
module judge_score_display
  import judge_score_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_judge_valid,
  input  logic [1:0]            i_judge,
  input  logic                  i_clear,
  output logic [4*DIGITS-1:0]   o_score,
  output logic [1:0]            o_judge,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_com
);

  localparam int SW = 4 * DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [SW-1:0] ALL_NINES  = {DIGITS{4'h9}};

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0]        SEG_OFF = 8'hFF;
  localparam logic [DIGITS-1:0] COM_OFF = '1;
`else
  localparam logic [7:0]        SEG_OFF = 8'h00;
  localparam logic [DIGITS-1:0] COM_OFF = '0;
`endif

  logic [SW-1:0]     score_reg;
  logic [1:0]        judge_reg;
  logic [TW-1:0]     timer_reg;
  logic [PW-1:0]     presc_reg;
  logic [IW-1:0]     idx_reg;
  logic [7:0]        seg_reg;
  logic [DIGITS-1:0] com_reg;

  logic                  strobe;
  logic [DIGITS:0][1:0]  carry;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         score_next;
  logic [DIGITS-1:0]     upper_zero;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [7:0]            glyph;

  assign strobe   = i_judge_valid && (i_judge != JUDGE_IDLE);
  assign carry[0] = judge_increment(i_judge);

  // Ripple decimal add; carry out of the top digit means the score would pass all-9s.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
    logic [4:0] raw;
    assign raw              = {1'b0, score_reg[4*gi +: 4]} + {3'b000, carry[gi]};
    assign carry[gi+1]      = (raw > 5'd9) ? 2'd1 : 2'd0;
    assign sum[4*gi +: 4]   = (raw > 5'd9) ? 4'(raw - 5'd10) : raw[3:0];
    assign upper_zero[gi]   = (score_reg[SW-1:4*gi] == '0);
  end

  assign score_next = (carry[DIGITS] != 2'd0) ? ALL_NINES : sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score_reg <= '0;
      judge_reg <= JUDGE_IDLE;
      timer_reg <= '0;
    end else if (i_clear) begin
      score_reg <= '0;
      judge_reg <= JUDGE_IDLE;
      timer_reg <= '0;
    end else if (strobe) begin
      score_reg <= score_next;
      judge_reg <= i_judge;
      timer_reg <= HOLD_LAST;
    end else if (judge_reg != JUDGE_IDLE) begin
      if (timer_reg == '0) judge_reg <= JUDGE_IDLE;
      else                 timer_reg <= timer_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign cur_digit = score_reg[{idx_reg, 2'b00} +: 4];
  assign cur_blank = (idx_reg != '0) && upper_zero[idx_reg];

  bcd_to_seg7 u_seg (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (glyph)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_reg <= SEG_OFF;
      com_reg <= COM_OFF;
    end else begin
      seg_reg <= glyph ^ SEG_OFF;
      com_reg <= (DIGITS'(1) << idx_reg) ^ COM_OFF;
    end
  end

  assign o_score = score_reg;
  assign o_judge = judge_reg;
  assign o_seg   = seg_reg;
  assign o_com   = com_reg;

endmodule
